// File: rtl/dog_pkg.sv
// dog_pkg: shared pixel widths, difference-mode encodings and coefficient slicing
package dog_pkg;
  localparam int PIX_W = 8;
  localparam int BLANK_BIT = 8;
  localparam int DIFF_WRAP = 0;
  localparam int DIFF_SAT = 1;
  // {h0,h1,h2} of stage k, h0 in the top byte of the 24-bit slice
  function automatic logic [7:0] coef(input logic [191:0] c, input int k, input int i);
    return c[24*k+16-8*i +: 8];
  endfunction
endpackage

// File: rtl/dog_align_delay.sv
// dog_align_delay: clock-enabled delay line; q is the sample pushed DEPTH enables ago
module dog_align_delay #(
  parameter int DEPTH = 1272,
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [0:DEPTH-1];
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      q <= '0;
    end else if (ce) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      q <= sr[DEPTH-1];
    end
  end
endmodule

// File: rtl/five_by_five_window.sv
// five_by_five_window: separable 5x5 Gaussian on a raster stream, window ending at the newest sample
module five_by_five_window import dog_pkg::*; #(
  parameter int WIDTH = 420,
  parameter logic [7:0] H0 = 8'd6,
  parameter logic [7:0] H1 = 8'd58,
  parameter logic [7:0] H2 = 8'd128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] din,
  input  logic             validin,
  input  logic             blanking_in,
  output logic [PIX_W-1:0] dout,
  output logic             validout,
  output logic             blanking_out
);
  localparam int TAPS = 4*WIDTH+5;
  logic [PIX_W-1:0] line [1:TAPS-1];
  logic [PIX_W-1:0] px [0:TAPS-1];
  logic [7:0] h [0:4];
  logic [19:0] row;
  logic [31:0] acc;
  assign h = '{H0, H1, H2, H1, H0};
  always_comb begin
    px[0] = din;
    for (int j = 1; j < TAPS; j++) px[j] = line[j];
  end
  // exact 2-D sum; the single >>16 keeps rounding independent of pass order
  always_comb begin
    acc = '0;
    row = '0;
    for (int r = 0; r < 5; r++) begin
      row = '0;
      for (int c = 0; c < 5; c++) row = row + 20'(h[c]) * 20'(px[r*WIDTH+c]);
      acc = acc + 32'(h[r]) * 32'(row);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 1; j < TAPS; j++) line[j] <= '0;
      dout <= '0;
      validout <= 1'b0;
      blanking_out <= 1'b0;
    end else begin
      validout <= validin;
      if (validin) begin
        for (int j = 1; j < TAPS; j++) line[j] <= px[j-1];
        dout <= |acc[31:24] ? 8'hff : acc[23:16];
        blanking_out <= blanking_in;
      end
    end
  end
endmodule

// File: rtl/dog_octave_param.sv
// dog_octave_param: Gaussian cascade, aligned DoG outputs and decimated next-octave stream
module dog_octave_param import dog_pkg::*; #(
  parameter int WIDTH = 420,
  parameter int SCALES = 5,
  parameter logic [24*SCALES-1:0] COEFFS = {8'd40, 8'd60, 8'd56, 8'd32, 8'd64, 8'd64,
                                            8'd24, 8'd64, 8'd80, 8'd16, 8'd64, 8'd96,
                                            8'd6, 8'd58, 8'd128},
  parameter int ALIGN_DLY = 3*WIDTH+12,
  parameter int DIFF_SHIFT = 3,
  parameter int DIFF_MODE = 0,
  parameter int NEXT_TAP = 3,
  parameter int DECIMATE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              din,
  input  logic                    validin,
  input  logic                    blanking_in,
  output logic [8*SCALES-1:0]     g_dout,
  output logic [SCALES-1:0]       g_valid,
  output logic [8*(SCALES-1)-1:0] d_dout,
  output logic [SCALES-2:0]       d_valid,
  output logic [7:0]              next_dout,
  output logic                    next_valid,
  output logic                    next_blanking
);
  localparam logic [191:0] CX = 192'(COEFFS);
  localparam int CW = $clog2(WIDTH);
  logic [SCALES-1:0] gv, gb;
  logic [SCALES-2:0] dv, db;
  logic [CW-1:0] col;
  logic parity, keep;
  assign g_valid = gv & ~gb;
  assign d_valid = dv & ~db;
  for (genvar k = 0; k < SCALES; k++) begin : g_stage
    logic [PIX_W-1:0] sd;
    logic sv, sb;
    if (k == 0) begin : g_first
      assign {sb, sv, sd} = {blanking_in, validin, din};
    end else begin : g_chain
      assign {sb, sv, sd} = {gb[k-1], gv[k-1], g_dout[8*k-8 +: 8]};
    end
    five_by_five_window #(.WIDTH(WIDTH), .H0(coef(CX, k, 0)), .H1(coef(CX, k, 1)),
                          .H2(coef(CX, k, 2))) u_win (
      .clock(clock), .reset(reset), .din(sd), .validin(sv), .blanking_in(sb),
      .dout(g_dout[8*k +: 8]), .validout(gv[k]), .blanking_out(gb[k]));
  end
  for (genvar k = 0; k < SCALES-1; k++) begin : g_dog
    logic [8:0] al, diff, mag;
    logic [16:0] sh;
    logic [7:0] val;
    logic unused_blank;
    dog_align_delay #(.DEPTH(ALIGN_DLY), .W(9)) u_align (
      .clock(clock), .reset(reset), .ce(gv[k]), .d({gb[k], g_dout[8*k +: 8]}), .q(al));
    assign unused_blank = al[BLANK_BIT];
    assign diff = {1'b0, al[7:0]} - {1'b0, g_dout[8*k+8 +: 8]};
    assign mag = diff[8] ? -diff : diff;
    assign sh = {8'd0, mag} << DIFF_SHIFT;
    assign val = DIFF_MODE == DIFF_SAT ? (|sh[16:8] ? 8'hff : sh[7:0]) : 8'(diff[7:0] << DIFF_SHIFT);
    always_ff @(posedge clock) begin
      if (reset) begin
        dv[k] <= 1'b0;
        db[k] <= 1'b1;
        d_dout[8*k +: 8] <= '0;
      end else begin
        dv[k] <= gv[k+1];
        if (gv[k+1]) begin
          db[k] <= gb[k+1];
          d_dout[8*k +: 8] <= val;
        end
      end
    end
  end
  // blanking samples still advance the phase so the next octave sees whole lines
  assign keep = gv[NEXT_TAP] && (DECIMATE == 0 || (!col[0] && !parity));
  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      parity <= 1'b0;
      next_dout <= '0;
      next_valid <= 1'b0;
      next_blanking <= 1'b0;
    end else begin
      next_valid <= keep;
      if (keep) begin
        next_dout <= g_dout[8*NEXT_TAP +: 8];
        next_blanking <= gb[NEXT_TAP];
      end
      if (gv[NEXT_TAP]) begin
        col <= col == CW'(WIDTH-1) ? '0 : col + CW'(1);
        parity <= parity ^ (col == CW'(WIDTH-1));
      end
    end
  end
endmodule

// File: tb/tb_dog_octave_param.sv
// tb_dog_octave_param: wrap/decimating and saturating/pass-through octaves against a convolution model
module tb_dog_octave_param;
  localparam int W = 16, S = 3, D = 60, SH = 3, NT = 1;
  localparam logic [71:0] CF = {8'd24, 8'd64, 8'd80, 8'd16, 8'd64, 8'd96, 8'd6, 8'd58, 8'd128};
  logic clock = 0, reset = 1, validin = 0, blanking_in = 0;
  logic [7:0] din = 0;
  logic [8*S-1:0] g_dout [2];
  logic [S-1:0] g_valid [2];
  logic [8*(S-1)-1:0] d_dout [2];
  logic [S-2:0] d_valid [2];
  logic [7:0] next_dout [2];
  logic next_valid [2], next_blanking [2];
  logic [71:0] cf = CF;
  int checks = 0, errors = 0;
  int hv [4096], hn [4096];
  int cyc = 0, last_rst = -1;
  int xs [S+1][$];
  bit bl [$];
  int npulse [2], nblank0, gcnt;
  bit rec;
  logic [7:0] recq [$], refq [$];
  logic [7:0] pix [128];

  always #5 clock = ~clock;

  for (genvar u = 0; u < 2; u++) begin : g_dut
    dog_octave_param #(.WIDTH(W), .SCALES(S), .COEFFS(CF), .ALIGN_DLY(D), .DIFF_SHIFT(SH),
                       .DIFF_MODE(u), .NEXT_TAP(NT), .DECIMATE(1-u)) dut (
      .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
      .g_dout(g_dout[u]), .g_valid(g_valid[u]), .d_dout(d_dout[u]), .d_valid(d_valid[u]),
      .next_dout(next_dout[u]), .next_valid(next_valid[u]), .next_blanking(next_blanking[u]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wt(int k, int i);
    int j;
    j = i <= 2 ? i : 4 - i;
    return int'(cf[24*k+16-8*j +: 8]);
  endfunction

  // 5x5 Gaussian of stage k over its input history, zero before the frame start
  function automatic int gauss(int k, int n);
    longint acc;
    acc = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (n - r*W - c >= 0) acc += longint'(wt(k, r) * wt(k, c)) * xs[k][n - r*W - c];
    acc = acc / 65536;
    return acc > 255 ? 255 : int'(acc);
  endfunction

  function automatic int dog(int mode, int k, int n);
    int a, e;
    a = n >= D ? xs[k+1][n-D] : 0;
    e = a - xs[k+2][n];
    if (mode == 0) return (e * (1 << SH)) & 255;
    e = (e < 0 ? -e : e) * (1 << SH);
    return e > 255 ? 255 : e;
  endfunction

  function automatic int sample_at(int lag);
    int s;
    s = cyc - lag;
    return (s > last_rst && s >= 0 && hv[s] != 0) ? hn[s] : -1;
  endfunction

  task automatic check();
    int n;
    bit e;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < S; k++) begin
        n = sample_at(k);
        e = n >= 0 && !bl[n];
        chk($sformatf("g_valid%0d_%0d", u, k), 32'(g_valid[u][k]), 32'(e));
        if (e) chk($sformatf("g_dout%0d_%0d_n%0d", u, k, n), 32'(g_dout[u][8*k +: 8]), xs[k+1][n]);
      end
      for (int k = 0; k < S-1; k++) begin
        n = sample_at(k+2);
        e = n >= 0 && !bl[n];
        chk($sformatf("d_valid%0d_%0d", u, k), 32'(d_valid[u][k]), 32'(e));
        if (e) chk($sformatf("d_dout%0d_%0d_n%0d", u, k, n), 32'(d_dout[u][8*k +: 8]), dog(u, k, n));
      end
      n = sample_at(NT+1);
      e = n >= 0 && (u == 1 || ((n % W) % 2 == 0 && (n / W) % 2 == 0));
      chk($sformatf("next_valid%0d_n%0d", u, n), 32'(next_valid[u]), 32'(e));
      if (e) begin
        chk($sformatf("next_dout%0d_n%0d", u, n), 32'(next_dout[u]), xs[NT+1][n]);
        chk($sformatf("next_blanking%0d_n%0d", u, n), 32'(next_blanking[u]), 32'(bl[n]));
      end
      if (next_valid[u]) npulse[u]++;
    end
    if (next_valid[0] && next_blanking[0]) nblank0++;
    if (g_valid[0][0]) gcnt++;
    if (rec && next_valid[0]) recq.push_back(next_dout[0]);
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic [7:0] d);
    reset = r; validin = v; blanking_in = b; din = d;
    @(posedge clock);
    if (r) begin
      last_rst = cyc;
      for (int k = 0; k <= S; k++) xs[k].delete();
      bl.delete();
    end
    hv[cyc] = (!r && v) ? 1 : 0;
    hn[cyc] = hv[cyc] != 0 ? xs[0].size() : -1;
    if (hv[cyc] != 0) begin
      xs[0].push_back(int'(d));
      bl.push_back(b);
      for (int k = 0; k < S; k++) xs[k+1].push_back(gauss(k, xs[0].size() - 1));
    end
    #1;
    check();
    cyc++;
  endtask

  task automatic flush();
    repeat (6) step(0, 0, 0, 8'd0);
  endtask

  task automatic clear_counts();
    npulse[0] = 0; npulse[1] = 0; nblank0 = 0; gcnt = 0;
  endtask

  initial begin
    repeat (3) step(1, 1, 0, 8'($urandom));
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_g_dout%0d", u), 32'(g_dout[u]), 0);
      chk($sformatf("rst_d_dout%0d", u), 32'(d_dout[u]), 0);
      chk($sformatf("rst_next_dout%0d", u), 32'(next_dout[u]), 0);
      chk($sformatf("rst_next_blanking%0d", u), 32'(next_blanking[u]), 0);
    end
    // flat frame with two blanking lines of fill
    clear_counts();
    for (int i = 0; i < 22*W; i++) step(0, 1, i < 2*W, 8'd100);
    flush();
    chk("flat_d_dout0", 32'(d_dout[0]), 0);
    chk("flat_d_dout1", 32'(d_dout[1]), 0);
    chk("blank_next_pulses", 32'(nblank0), 8);
    chk("flat_g0_count", 32'(gcnt), 20*W);
    // 16 random lines: decimation density
    step(1, 0, 0, 8'd0);
    clear_counts();
    for (int i = 0; i < 16*W; i++) step(0, 1, 0, 8'($urandom));
    flush();
    chk("decim_count", 32'(npulse[0]), 64);
    chk("pass_count", 32'(npulse[1]), 256);
    // gapped stream with blanking fill
    step(1, 0, 0, 8'd0);
    for (int i = 0; i < 12*W;) begin
      if ($urandom_range(0, 3) != 0) begin
        step(0, 1, i < 2*W, 8'($urandom));
        i++;
      end else step(0, 0, 0, 8'($urandom));
    end
    flush();
    // mid-frame reset must reproduce a clean run
    for (int i = 0; i < 8*W; i++) pix[i] = 8'($urandom);
    step(1, 0, 0, 8'd0);
    recq.delete();
    rec = 1;
    for (int i = 0; i < 8*W; i++) step(0, 1, 0, pix[i]);
    flush();
    refq = recq;
    recq.delete();
    step(1, 0, 0, 8'd0);
    for (int i = 0; i < 5*W+7; i++) step(0, 1, 0, pix[i]);
    step(1, 1, 0, 8'd0);
    step(1, 1, 0, 8'd0);
    recq.delete();
    for (int i = 0; i < 8*W; i++) step(0, 1, 0, pix[i]);
    flush();
    rec = 0;
    chk("restart_len", 32'(recq.size()), 32'(refq.size()));
    for (int i = 0; i < refq.size() && i < recq.size(); i++)
      chk($sformatf("restart_px%0d", i), 32'(recq[i]), 32'(refq[i]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
